dac_pattern_gen: RTL and testbench

Parametrised multi-channel DAC pattern generator and interleaver, the successor to the fixed two-channel constant-value DAC test block. Per channel it produces a constant, ramp or square pattern from run-time configuration, converts two's-complement samples to offset binary, and time-multiplexes all channels onto one registered DAC data bus with a channel tag. It sits between the servo/config logic and the DAC output serialiser/pin driver.

---
 rtl/dac_pkg.sv | 25 ++
 rtl/dac_ch_gen.sv | 78 +++++++
 rtl/dac_pattern_gen.sv | 126 ++++++++++++
 tb/tb_dac_pattern_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC pattern generator.
// Mode encoding and offset-binary conversion used by all channel generators.
package dac_pkg;

   localparam int MAX_DW = 64;

   typedef enum logic [1:0] {
      MODE_CONST  = 2'd0,
      MODE_RAMP   = 2'd1,
      MODE_SQUARE = 2'd2,
      MODE_OFF    = 2'd3
   } mode_e;

   // Midscale code (only the MSB set) for a dw-bit converter, dw <= MAX_DW.
   function automatic logic [MAX_DW-1:0] midscale(input int dw);
      return MAX_DW'(1) << (dw - 1);
   endfunction

   // Two's complement to offset binary is a plain MSB inversion.
   function automatic logic [MAX_DW-1:0] to_offset_binary(input logic [MAX_DW-1:0] sample,
                                                          input int                dw);
      return sample ^ midscale(dw);
   endfunction

endpackage

// File: rtl/dac_ch_gen.sv
// One DAC channel: active configuration plus ramp/square running state.
// load copies a committed config in; advance steps the pattern after the channel's slot.
module dac_ch_gen
   import dac_pkg::*;
#(
   parameter int DW = 16,
   parameter int PW = 16
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          load,
   input  logic          advance,
   input  mode_e         cfg_mode,
   input  logic [DW-1:0] cfg_value,
   input  logic [DW-1:0] cfg_step,
   input  logic [PW-1:0] cfg_period,
   output logic [DW-1:0] sample
);

   mode_e         mode;
   logic [DW-1:0] value;
   logic [DW-1:0] step;
   logic [DW-1:0] acc;
   logic [PW-1:0] period;
   logic [PW-1:0] half_cnt;
   logic [PW-1:0] half_last;
   logic          phase;

   // A zero half-period behaves like one frame.
   always_comb begin
      half_last = (period == '0) ? '0 : period - PW'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         mode     <= MODE_OFF;
         value    <= '0;
         step     <= '0;
         period   <= PW'(1);
         acc      <= '0;
         half_cnt <= '0;
         phase    <= 1'b1;
      end else if (load) begin
         mode     <= cfg_mode;
         value    <= cfg_value;
         step     <= cfg_step;
         period   <= cfg_period;
         acc      <= cfg_value;
         half_cnt <= '0;
         phase    <= 1'b1;
      end else if (advance) begin
         if (mode == MODE_RAMP) begin
            acc <= acc + step;
         end
         if (mode == MODE_SQUARE) begin
            if (half_cnt >= half_last) begin
               half_cnt <= '0;
               phase    <= ~phase;
            end else begin
               half_cnt <= half_cnt + PW'(1);
            end
         end
      end
   end

   // NOTE: default assigned first so no path through the case can infer a latch.
   always_comb begin
      sample = '0;
      case (mode)
         MODE_CONST:  sample = value;
         MODE_RAMP:   sample = acc;
         MODE_SQUARE: sample = phase ? value : step;
         default:     sample = '0;
      endcase
   end

endmodule

// File: rtl/dac_pattern_gen.sv
// Multi-channel DAC pattern generator and slot interleaver.
// Shadow config commits only at frame boundaries or while disabled, so channels never change mid-frame.
module dac_pattern_gen
   import dac_pkg::*;
#(
   parameter  int N_CH = 2,
   parameter  int DW   = 16,
   parameter  int PW   = 16,
   localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          enable,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic [1:0]    cfg_mode,
   input  logic [DW-1:0] cfg_value,
   input  logic [DW-1:0] cfg_step,
   input  logic [PW-1:0] cfg_period,
   output logic [DW-1:0] dac_data,
   output logic [CW-1:0] dac_sel,
   output logic          frame_start,
   output logic          cfg_pending
);

   localparam logic [DW-1:0] MIDSCALE = DW'(midscale(DW));

   logic [CW-1:0]   slot;
   logic            last_slot;
   logic            commit;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] pending_next;
   logic [N_CH-1:0] write_mask;
   logic [N_CH-1:0] load_mask;
   logic [N_CH-1:0] advance_mask;
   logic [DW-1:0]   ob_sample;

   mode_e           shadow_mode   [N_CH];
   logic [DW-1:0]   shadow_value  [N_CH];
   logic [DW-1:0]   shadow_step   [N_CH];
   logic [PW-1:0]   shadow_period [N_CH];
   logic [DW-1:0]   samples       [N_CH];

   // Commit reads the registered shadow, so a write on the commit cycle waits for the next one.
   always_comb begin
      last_slot    = (slot == CW'(N_CH - 1));
      commit       = !enable || last_slot;
      write_mask   = '0;
      load_mask    = '0;
      advance_mask = '0;
      for (int c = 0; c < N_CH; c++) begin
         write_mask[c]   = cfg_we && (cfg_ch == CW'(c));
         load_mask[c]    = commit && pending[c];
         advance_mask[c] = enable && (slot == CW'(c));
      end
      pending_next = (pending & ~load_mask) | write_mask;
   end

   // NOTE: shadow arrays are ordinary flops, not RAM, so they take the synchronous reset too.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         for (int c = 0; c < N_CH; c++) begin
            shadow_mode[c]   <= MODE_OFF;
            shadow_value[c]  <= '0;
            shadow_step[c]   <= '0;
            shadow_period[c] <= PW'(1);
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (write_mask[c]) begin
               shadow_mode[c]   <= mode_e'(cfg_mode);
               shadow_value[c]  <= cfg_value;
               shadow_step[c]   <= cfg_step;
               shadow_period[c] <= cfg_period;
            end
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      dac_ch_gen #(
         .DW (DW),
         .PW (PW)
      ) u_ch (
         .clk_in     (clk_in),
         .rst_n_in   (rst_n_in),
         .load       (load_mask[c]),
         .advance    (advance_mask[c]),
         .cfg_mode   (shadow_mode[c]),
         .cfg_value  (shadow_value[c]),
         .cfg_step   (shadow_step[c]),
         .cfg_period (shadow_period[c]),
         .sample     (samples[c])
      );
   end

   always_comb begin
      ob_sample = DW'(to_offset_binary(MAX_DW'(samples[slot]), DW));
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         slot        <= '0;
         pending     <= '0;
         cfg_pending <= 1'b0;
         dac_data    <= MIDSCALE;
         dac_sel     <= '0;
         frame_start <= 1'b0;
      end else begin
         pending     <= pending_next;
         cfg_pending <= |pending_next;
         if (enable) begin
            slot        <= last_slot ? '0 : slot + CW'(1);
            dac_data    <= ob_sample;
            dac_sel     <= slot;
            frame_start <= (slot == '0);
         end else begin
            slot        <= '0;
            dac_data    <= MIDSCALE;
            dac_sel     <= '0;
            frame_start <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dac_pattern_gen.sv
// Scoreboard bench for dac_pattern_gen: a frame-level reference model predicts each cycle's outputs.
// Ramp/square values are computed in closed form from frames elapsed since the last commit.
module tb_dac_pattern_gen;

   localparam int N_CH = 2;
   localparam int DW   = 16;
   localparam int PW   = 16;
   localparam int CW   = 1;

   logic          clk_in     = 1'b0;
   logic          rst_n_in   = 1'b0;
   logic          enable     = 1'b0;
   logic          cfg_we     = 1'b0;
   logic [CW-1:0] cfg_ch     = '0;
   logic [1:0]    cfg_mode   = 2'd0;
   logic [DW-1:0] cfg_value  = '0;
   logic [DW-1:0] cfg_step   = '0;
   logic [PW-1:0] cfg_period = '0;
   logic [DW-1:0] dac_data;
   logic [CW-1:0] dac_sel;
   logic          frame_start;
   logic          cfg_pending;

   dac_pattern_gen #(
      .N_CH (N_CH),
      .DW   (DW),
      .PW   (PW)
   ) dut (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .enable      (enable),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_mode    (cfg_mode),
      .cfg_value   (cfg_value),
      .cfg_step    (cfg_step),
      .cfg_period  (cfg_period),
      .dac_data    (dac_data),
      .dac_sel     (dac_sel),
      .frame_start (frame_start),
      .cfg_pending (cfg_pending)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [DW-1:0] data;
      logic [CW-1:0] sel;
      logic          fs;
      logic          pend;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: active/shadow config per channel and frames played since commit.
   int            m_slot;
   bit            m_pend   [N_CH];
   int            sh_mode  [N_CH];
   int            ac_mode  [N_CH];
   logic [DW-1:0] sh_val   [N_CH];
   logic [DW-1:0] ac_val   [N_CH];
   logic [DW-1:0] sh_step  [N_CH];
   logic [DW-1:0] ac_step  [N_CH];
   logic [PW-1:0] sh_per   [N_CH];
   logic [PW-1:0] ac_per   [N_CH];
   longint        k        [N_CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_slot = 0;
      for (int c = 0; c < N_CH; c++) begin
         m_pend[c]  = 1'b0;
         sh_mode[c] = 3;
         ac_mode[c] = 3;
         sh_val[c]  = '0;
         ac_val[c]  = '0;
         sh_step[c] = '0;
         ac_step[c] = '0;
         sh_per[c]  = PW'(1);
         ac_per[c]  = PW'(1);
         k[c]       = 0;
      end
   endtask

   function automatic logic [DW-1:0] model_sample(input int c);
      longint half;
      case (ac_mode[c])
         0: return ac_val[c];
         1: return DW'(longint'(ac_val[c]) + k[c] * longint'(ac_step[c]));
         2: begin
            half = (ac_per[c] == '0) ? 1 : longint'(ac_per[c]);
            return (((k[c] / half) % 2) == 0) ? ac_val[c] : ac_step[c];
         end
         default: return '0;
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit en, input bit we, input int ch,
                             input int mode, input logic [DW-1:0] v, input logic [DW-1:0] s,
                             input logic [PW-1:0] p);
      exp_t e;
      int   cur;
      if (rst) begin
         model_reset();
         e.data = 16'h8000;
         e.sel  = '0;
         e.fs   = 1'b0;
         e.pend = 1'b0;
      end else begin
         cur = m_slot;
         if (en) begin
            e.data = model_sample(cur) ^ 16'h8000;
            e.sel  = CW'(cur);
            e.fs   = (cur == 0);
            k[cur]++;
         end else begin
            e.data = 16'h8000;
            e.sel  = '0;
            e.fs   = 1'b0;
         end
         if (!en || cur == N_CH - 1) begin
            for (int c = 0; c < N_CH; c++) begin
               if (m_pend[c]) begin
                  ac_mode[c] = sh_mode[c];
                  ac_val[c]  = sh_val[c];
                  ac_step[c] = sh_step[c];
                  ac_per[c]  = sh_per[c];
                  k[c]       = 0;
                  m_pend[c]  = 1'b0;
               end
            end
         end
         if (we && ch < N_CH) begin
            sh_mode[ch] = mode;
            sh_val[ch]  = v;
            sh_step[ch] = s;
            sh_per[ch]  = p;
            m_pend[ch]  = 1'b1;
         end
         m_slot = en ? (cur + 1) % N_CH : 0;
         e.pend = 1'b0;
         for (int c = 0; c < N_CH; c++) e.pend = e.pend | m_pend[c];
      end
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit rst, input bit en, input bit we, input int ch, input int mode,
                        input logic [DW-1:0] v, input logic [DW-1:0] s, input logic [PW-1:0] p);
      @(negedge clk_in);
      rst_n_in   = !rst;
      enable     = en;
      cfg_we     = we;
      cfg_ch     = CW'(ch);
      cfg_mode   = 2'(mode);
      cfg_value  = v;
      cfg_step   = s;
      cfg_period = p;
      model_step(rst, en, we, ch, mode, v, s, p);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, '0, '0, '0);
   endtask

   task automatic wr(input int ch, input int mode, input logic [DW-1:0] v,
                     input logic [DW-1:0] s, input logic [PW-1:0] p);
      drive(0, 1, 1, ch, mode, v, s, p);
   endtask

   task automatic to_last_slot();
      for (int i = 0; i < N_CH && m_slot != N_CH - 1; i++) run(1);
   endtask

   // Monitor: every cycle the DUT presents a new registered sample one step after the edge.
   always begin
      exp_t e;
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("dac_data", 32'(dac_data), 32'(e.data));
         check("dac_sel", 32'(dac_sel), 32'(e.sel));
         check("frame_start", 32'(frame_start), 32'(e.fs));
         check("cfg_pending", 32'(cfg_pending), 32'(e.pend));
      end
   end

   initial begin
      model_reset();
      drive(1, 0, 0, 0, 0, '0, '0, '0);
      drive(1, 0, 0, 0, 0, '0, '0, '0);
      run(6);
      // Constants written mid-frame.
      run(1);
      wr(0, 0, 16'h1234, '0, '0);
      wr(1, 0, 16'hFFFF, '0, '0);
      run(8);
      // Ramp across the signed wrap point.
      wr(0, 1, 16'h7FFE, 16'h0001, '0);
      run(12);
      // Square with half-period 3, then 0.
      wr(1, 2, 16'h0100, 16'hFF00, 16'd3);
      run(28);
      wr(1, 2, 16'h0100, 16'hFF00, 16'd0);
      run(10);
      // Two writes before commit, then a write on the commit cycle.
      run(1);
      wr(0, 0, 16'h1111, '0, '0);
      to_last_slot();
      wr(0, 0, 16'h2222, '0, '0);
      run(6);
      to_last_slot();
      wr(1, 0, 16'h0ABC, '0, '0);
      run(6);
      // Disabled cycles commit immediately and hold pattern state.
      drive(0, 0, 1, 0, 1, 16'h0010, 16'h0003, '0);
      drive(0, 0, 0, 0, 0, '0, '0, '0);
      run(7);
      drive(0, 0, 0, 0, 0, '0, '0, '0);
      run(6);
      // Reset in the middle of a frame during a ramp.
      wr(0, 1, 16'h7FFE, 16'h0001, '0);
      run(5);
      drive(1, 1, 0, 0, 0, '0, '0, '0);
      run(6);
      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 5) == 0, int'($urandom_range(0, N_CH - 1)),
               int'($urandom_range(0, 3)), DW'($urandom), DW'($urandom),
               PW'($urandom_range(0, 4)));
      end
      run(2);
      @(negedge clk_in);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
